chess_turn_ctrl: RTL and testbench
==================================

Name: chess_turn_ctrl

Overview:
- Game sequencer between the debounced Nexys4 buttons and the chessboard datapath.
- Owns the cursor and enforces alternating turns: only the side to move may pick up its own piece.
- Issues one move command per turn to the board over a req/ack handshake.
- Runs a two-player countdown chess clock and declares game over on flag fall.

Parameters:
- CLK_PER_SEC, 100000000, clk cycles per clock-second tick (min 2)
- START_SECS, 300, initial seconds on each player's clock (max 8191)
- INC_SECS, 2, per-move increment, used only with CHESS_INC_EN

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- btn_up / btn_down / btn_left / btn_right / btn_sel  in  1 each  single-cycle button pulses
- sq_team  in  3  one-hot team of the square at (cursor_x, cursor_y): 001 NA, 010 WHITE, 100 BLACK
- move_ack  in  1  board has applied the move
- cursor_x, cursor_y  out  3 each  cursor square
- picked  out  1  a source square is held
- src_x, src_y  out  3 each  held source square
- dst_x, dst_y  out  3 each  move destination
- move_req  out  1  move command valid
- turn  out  1  side to move: 0 white, 1 black
- white_secs, black_secs  out  13 each  remaining seconds
- move_count  out  10  completed moves, saturating at 1023
- game_over  out  1  game has ended
- winner  out  1  winning side, valid while game_over

Behaviour:
- Reset values (async):
  - cursor 0,0; src/dst 0; picked 0; move_req 0
  - turn 0; both clocks START_SECS; move_count 0
  - game_over 0; winner 0; state PICK; started 0; prescaler 0
- Button priority, one action per cycle: right > left > up > down > sel.
- Cursor moves wrap modulo 8.
  - Up decrements y; down increments y.
  - Cursor moves are accepted in PICK and PLACE; ignored in ISSUE and OVER.
- State PICK:
  - sel with sq_team == own team (WHITE if turn=0, else BLACK): src <= cursor, picked <= 1, go to PLACE.
  - sel on any other square: ignored.
- State PLACE:
  - sel on the src square: cancel; picked <= 0; go to PICK.
  - sel on another own-team square: src <= cursor; stay in PLACE.
  - sel on any other square: dst <= cursor; move_req <= 1 next cycle; go to ISSUE.
- State ISSUE:
  - move_req held high with src/dst stable until move_ack is sampled high.
  - On that cycle: move_req <= 0, picked <= 0, turn toggles, move_count++, started <= 1, prescaler <= 0; go to PICK.
  - move_ack outside ISSUE is ignored.
- Clock:
  - Prescaler counts 0..CLK_PER_SEC-1 only when started=1, state is PICK or PLACE, and game_over=0.
  - Wrap produces a tick that decrements the side-to-move's seconds.
  - The first white move is untimed.
  - The clock is paused in ISSUE.
- Flag fall: a tick that takes the mover's seconds to 0 sets game_over=1, winner=~turn, state OVER.
  - picked and move_req are forced to 0.
  - Seconds never go below 0.
- OVER: all inputs ignored until rst.
- rst in ISSUE drops move_req immediately (asynchronous); the board is not expected to hold a half-applied move.

Optional Feature:
- CHESS_INC_EN defined: on each completed move (ack cycle), the mover's seconds += INC_SECS, saturating at 8191.
- Not defined: no increment; the INC_SECS parameter is unused.

Decomposition:
- chess_pkg: team one-hot constants (NA/WHITE/BLACK), piece one-hot constants, state encoding (PICK, PLACE, ISSUE, OVER), SECS_W=13, COUNT_W=10.
- Sub-module chess_clock:
  - contains the prescaler plus both second counters with decrement, increment and zero detect;
  - inputs: run, turn, prescaler clear, increment;
  - outputs: both seconds values and a flag pulse.

Test Plan:
- rst -> cursor 0,0, turn 0, white_secs = black_secs = 300, move_req 0, game_over 0.
- cursor at (7,3), right -> (0,3); cursor at (2,0), up -> (2,7); right+sel in the same cycle -> moves cursor only, no pick.
- turn 0, sel with sq_team=100 -> picked stays 0. Then sel with sq_team=010 at (4,6) -> picked 1, src (4,6). Then sel at (4,4) with NA -> move_req 1, dst (4,4).
- move_req held with move_ack low for 5 cycles -> src/dst stable. move_ack 1 -> next cycle move_req 0, turn 1, move_count 1.
- CLK_PER_SEC=4, START_SECS=2, after the first move, no input -> black_secs 2→1→0 at 4-cycle intervals; at 0, game_over 1, winner 0, btn_sel ignored.
- With CHESS_INC_EN, START_SECS=8190, INC_SECS=5, complete a black move -> black_secs 8191 (saturated).

Source files
------------

// File: rtl/chess_pkg.sv
// Shared encodings for the chess game sequencer: team/piece one-hots, FSM states, widths.
package chess_pkg;

  localparam int unsigned SECS_W   = 13;
  localparam int unsigned COUNT_W  = 10;
  localparam int unsigned SECS_MAX = (2 ** SECS_W) - 1;

  localparam logic [2:0] TEAM_NA    = 3'b001;
  localparam logic [2:0] TEAM_WHITE = 3'b010;
  localparam logic [2:0] TEAM_BLACK = 3'b100;

  localparam logic [5:0] PIECE_PAWN   = 6'b000001;
  localparam logic [5:0] PIECE_KNIGHT = 6'b000010;
  localparam logic [5:0] PIECE_BISHOP = 6'b000100;
  localparam logic [5:0] PIECE_ROOK   = 6'b001000;
  localparam logic [5:0] PIECE_QUEEN  = 6'b010000;
  localparam logic [5:0] PIECE_KING   = 6'b100000;

  typedef enum logic [1:0] {
    StPick,
    StPlace,
    StIssue,
    StOver
  } state_e;

  function automatic logic [2:0] own_team(input logic turn);
    return turn ? TEAM_BLACK : TEAM_WHITE;
  endfunction

endpackage

// File: rtl/chess_clock.sv
// Two-player countdown clock: prescaler, per-side seconds, flag-fall pulse.
// Optional per-move increment is enabled by defining CHESS_INC_EN.
module chess_clock
  import chess_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC = 100000000,
  parameter int unsigned START_SECS  = 300,
  parameter int unsigned INC_SECS    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_i,
  input  logic              turn_i,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [SECS_W-1:0] white_secs_o,
  output logic [SECS_W-1:0] black_secs_o,
  output logic              flag_o
);

  localparam int unsigned PW = $clog2(CLK_PER_SEC);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_SEC - 1);

  logic [PW-1:0]     presc_q, presc_d;
  logic [SECS_W-1:0] white_q, white_d, black_q, black_d;
  logic [SECS_W-1:0] mover_secs, mover_next;
  logic              tick;

  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (clr_i) begin
      presc_d = '0;
    end else if (run_i) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  assign mover_secs = turn_i ? black_q : white_q;
  // Pulses on the tick that brings the mover to zero (or finds it already there).
  assign flag_o     = tick && (mover_secs <= SECS_W'(1));

`ifdef CHESS_INC_EN
  logic [31:0] inc_sum;
  assign inc_sum = 32'(mover_secs) + INC_SECS;
`else
  logic unused_inc;
  assign unused_inc = inc_i ^ (^INC_SECS);
`endif

  always_comb begin
    white_d    = white_q;
    black_d    = black_q;
    mover_next = mover_secs;
    if (tick && (mover_secs != '0)) begin
      mover_next = mover_secs - 1'b1;
    end
`ifdef CHESS_INC_EN
    if (inc_i) begin
      mover_next = (inc_sum > SECS_MAX) ? SECS_W'(SECS_MAX) : inc_sum[SECS_W-1:0];
    end
`endif
    if (turn_i) begin
      black_d = mover_next;
    end else begin
      white_d = mover_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      white_q <= SECS_W'(START_SECS);
      black_q <= SECS_W'(START_SECS);
    end else begin
      presc_q <= presc_d;
      white_q <= white_d;
      black_q <= black_d;
    end
  end

  assign white_secs_o = white_q;
  assign black_secs_o = black_q;

endmodule

// File: rtl/chess_turn_ctrl.sv
// Game sequencer: cursor, turn-enforced pick/place, move req/ack and chess clock.
// Define CHESS_INC_EN to add INC_SECS to the mover's clock on each completed move.
module chess_turn_ctrl
  import chess_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC = 100000000,
  parameter int unsigned START_SECS  = 300,
  parameter int unsigned INC_SECS    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_up_i,
  input  logic               btn_down_i,
  input  logic               btn_left_i,
  input  logic               btn_right_i,
  input  logic               btn_sel_i,
  input  logic [2:0]         sq_team_i,
  input  logic               move_ack_i,
  output logic [2:0]         cursor_x_o,
  output logic [2:0]         cursor_y_o,
  output logic               picked_o,
  output logic [2:0]         src_x_o,
  output logic [2:0]         src_y_o,
  output logic [2:0]         dst_x_o,
  output logic [2:0]         dst_y_o,
  output logic               move_req_o,
  output logic               turn_o,
  output logic [SECS_W-1:0]  white_secs_o,
  output logic [SECS_W-1:0]  black_secs_o,
  output logic [COUNT_W-1:0] move_count_o,
  output logic               game_over_o,
  output logic               winner_o
);

  state_e             state_q, state_d;
  logic [2:0]         cx_q, cx_d, cy_q, cy_d;
  logic [2:0]         src_x_q, src_x_d, src_y_q, src_y_d;
  logic [2:0]         dst_x_q, dst_x_d, dst_y_q, dst_y_d;
  logic               picked_q, picked_d, req_q, req_d, turn_q, turn_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               over_q, over_d, winner_q, winner_d, started_q, started_d;
  logic               run, clk_clr, clk_inc, flag;
  logic               own_sq, on_src;

  assign own_sq = (sq_team_i == own_team(turn_q));
  assign on_src = (cx_q == src_x_q) && (cy_q == src_y_q);
  // The first white move is untimed; the clock also stops while a move is in flight.
  assign run    = started_q && ((state_q == StPick) || (state_q == StPlace)) && !over_q;

  chess_clock #(
    .CLK_PER_SEC (CLK_PER_SEC),
    .START_SECS  (START_SECS),
    .INC_SECS    (INC_SECS)
  ) u_clock (
    .clk          (clk),
    .rst          (rst),
    .run_i        (run),
    .turn_i       (turn_q),
    .clr_i        (clk_clr),
    .inc_i        (clk_inc),
    .white_secs_o (white_secs_o),
    .black_secs_o (black_secs_o),
    .flag_o       (flag)
  );

  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    src_x_d   = src_x_q;
    src_y_d   = src_y_q;
    dst_x_d   = dst_x_q;
    dst_y_d   = dst_y_q;
    picked_d  = picked_q;
    req_d     = req_q;
    turn_d    = turn_q;
    count_d   = count_q;
    over_d    = over_q;
    winner_d  = winner_q;
    started_d = started_q;
    clk_clr   = 1'b0;
    clk_inc   = 1'b0;

    unique case (state_q)
      StPick, StPlace: begin
        if (btn_right_i) begin
          cx_d = cx_q + 3'd1;
        end else if (btn_left_i) begin
          cx_d = cx_q - 3'd1;
        end else if (btn_up_i) begin
          cy_d = cy_q - 3'd1;
        end else if (btn_down_i) begin
          cy_d = cy_q + 3'd1;
        end else if (btn_sel_i) begin
          if (state_q == StPick) begin
            if (own_sq) begin
              src_x_d  = cx_q;
              src_y_d  = cy_q;
              picked_d = 1'b1;
              state_d  = StPlace;
            end
          end else if (on_src) begin
            picked_d = 1'b0;
            state_d  = StPick;
          end else if (own_sq) begin
            src_x_d = cx_q;
            src_y_d = cy_q;
          end else begin
            dst_x_d = cx_q;
            dst_y_d = cy_q;
            req_d   = 1'b1;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (move_ack_i) begin
          req_d     = 1'b0;
          picked_d  = 1'b0;
          turn_d    = ~turn_q;
          count_d   = (count_q != {COUNT_W{1'b1}}) ? count_q + 1'b1 : count_q;
          started_d = 1'b1;
          clk_clr   = 1'b1;
          clk_inc   = 1'b1;
          state_d   = StPick;
        end
      end
      StOver: begin
      end
      default: begin
      end
    endcase

    if (flag) begin
      over_d   = 1'b1;
      winner_d = ~turn_q;
      picked_d = 1'b0;
      req_d    = 1'b0;
      state_d  = StOver;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StPick;
      cx_q      <= '0;
      cy_q      <= '0;
      src_x_q   <= '0;
      src_y_q   <= '0;
      dst_x_q   <= '0;
      dst_y_q   <= '0;
      picked_q  <= 1'b0;
      req_q     <= 1'b0;
      turn_q    <= 1'b0;
      count_q   <= '0;
      over_q    <= 1'b0;
      winner_q  <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
      src_x_q   <= src_x_d;
      src_y_q   <= src_y_d;
      dst_x_q   <= dst_x_d;
      dst_y_q   <= dst_y_d;
      picked_q  <= picked_d;
      req_q     <= req_d;
      turn_q    <= turn_d;
      count_q   <= count_d;
      over_q    <= over_d;
      winner_q  <= winner_d;
      started_q <= started_d;
    end
  end

  assign cursor_x_o   = cx_q;
  assign cursor_y_o   = cy_q;
  assign picked_o     = picked_q;
  assign src_x_o      = src_x_q;
  assign src_y_o      = src_y_q;
  assign dst_x_o      = dst_x_q;
  assign dst_y_o      = dst_y_q;
  assign move_req_o   = req_q;
  assign turn_o       = turn_q;
  assign move_count_o = count_q;
  assign game_over_o  = over_q;
  assign winner_o     = winner_q;

endmodule

// File: tb/tb_chess_turn_ctrl.sv
// Scoreboard bench: unit 0 exercises cursor/turn/handshake, unit 1 the flag fall.
module tb_chess_turn_ctrl;

`ifdef CHESS_INC_EN
  localparam int unsigned A_START = 8190;
  localparam int unsigned A_INC   = 5;
  localparam int          A_AFTER = 8191;
`else
  localparam int unsigned A_START = 300;
  localparam int unsigned A_INC   = 2;
  localparam int          A_AFTER = 300;
`endif

  localparam int FCX = 0, FCY = 1, FPICK = 2, FSX = 3, FSY = 4, FDX = 5, FDY = 6;
  localparam int FREQ = 7, FTURN = 8, FWS = 9, FBS = 10, FCNT = 11, FGO = 12, FWIN = 13;
  localparam int FMOVE = 14;

  localparam logic [4:0] B_RIGHT = 5'b00001, B_LEFT = 5'b00010, B_UP = 5'b00100;
  localparam logic [4:0] B_DOWN = 5'b01000, B_SEL = 5'b10000;
  localparam logic [2:0] NA = 3'b001, WH = 3'b010, BL = 3'b100;

  typedef struct {
    string name;
    int    unit;
    int    field;
    int    exp;
  } snap_t;

  logic        clk, rst;
  logic [4:0]  btn   [2];
  logic [2:0]  team  [2];
  logic        ack   [2];
  logic [2:0]  cx    [2];
  logic [2:0]  cy    [2];
  logic        pk    [2];
  logic [2:0]  sx    [2];
  logic [2:0]  sy    [2];
  logic [2:0]  dx    [2];
  logic [2:0]  dy    [2];
  logic        req   [2];
  logic        turn  [2];
  logic [12:0] ws    [2];
  logic [12:0] bs    [2];
  logic [9:0]  cnt   [2];
  logic        go    [2];
  logic        win   [2];

  snap_t snap_q[$];
  int    mv_q[$];
  int    win_q[$];
  int    checks = 0;
  int    failures = 0;
  logic  done = 1'b0;
  logic  req_prev = 1'b0;
  logic  go_prev = 1'b0;

  chess_turn_ctrl #(
    .CLK_PER_SEC (1000),
    .START_SECS  (A_START),
    .INC_SECS    (A_INC)
  ) u_dut_a (
    .clk (clk), .rst (rst),
    .btn_up_i (btn[0][2]), .btn_down_i (btn[0][3]), .btn_left_i (btn[0][1]),
    .btn_right_i (btn[0][0]), .btn_sel_i (btn[0][4]), .sq_team_i (team[0]),
    .move_ack_i (ack[0]), .cursor_x_o (cx[0]), .cursor_y_o (cy[0]), .picked_o (pk[0]),
    .src_x_o (sx[0]), .src_y_o (sy[0]), .dst_x_o (dx[0]), .dst_y_o (dy[0]),
    .move_req_o (req[0]), .turn_o (turn[0]), .white_secs_o (ws[0]), .black_secs_o (bs[0]),
    .move_count_o (cnt[0]), .game_over_o (go[0]), .winner_o (win[0])
  );

  chess_turn_ctrl #(
    .CLK_PER_SEC (4),
    .START_SECS  (2),
    .INC_SECS    (0)
  ) u_dut_b (
    .clk (clk), .rst (rst),
    .btn_up_i (btn[1][2]), .btn_down_i (btn[1][3]), .btn_left_i (btn[1][1]),
    .btn_right_i (btn[1][0]), .btn_sel_i (btn[1][4]), .sq_team_i (team[1]),
    .move_ack_i (ack[1]), .cursor_x_o (cx[1]), .cursor_y_o (cy[1]), .picked_o (pk[1]),
    .src_x_o (sx[1]), .src_y_o (sy[1]), .dst_x_o (dx[1]), .dst_y_o (dy[1]),
    .move_req_o (req[1]), .turn_o (turn[1]), .white_secs_o (ws[1]), .black_secs_o (bs[1]),
    .move_count_o (cnt[1]), .game_over_o (go[1]), .winner_o (win[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pack_mv(input int sxv, input int syv, input int dxv, input int dyv);
    return (sxv << 9) | (syv << 6) | (dxv << 3) | dyv;
  endfunction

  function automatic int get_f(input int u, input int f);
    case (f)
      FCX:     return int'(cx[u]);
      FCY:     return int'(cy[u]);
      FPICK:   return int'(pk[u]);
      FSX:     return int'(sx[u]);
      FSY:     return int'(sy[u]);
      FDX:     return int'(dx[u]);
      FDY:     return int'(dy[u]);
      FREQ:    return int'(req[u]);
      FTURN:   return int'(turn[u]);
      FWS:     return int'(ws[u]);
      FBS:     return int'(bs[u]);
      FCNT:    return int'(cnt[u]);
      FGO:     return int'(go[u]);
      FWIN:    return int'(win[u]);
      default: return pack_mv(int'(sx[u]), int'(sy[u]), int'(dx[u]), int'(dy[u]));
    endcase
  endfunction

  task automatic expect_f(input int u, input int f, input int e, input string name);
    snap_t s;
    s.name = name; s.unit = u; s.field = f; s.exp = e;
    snap_q.push_back(s);
  endtask

  // One-cycle button pulse; returns just after the edge that consumed it.
  task automatic press(input int u, input logic [4:0] b, input logic [2:0] t);
    @(posedge clk); #1;
    btn[u] = b; team[u] = t;
    @(posedge clk); #1;
    btn[u] = '0;
  endtask

  task automatic ack_pulse(input int u);
    ack[u] = 1'b1;
    @(posedge clk); #1;
    ack[u] = 1'b0;
  endtask

  // Single checking process: snapshot queue, move_req and game_over events, final drain.
  always @(negedge clk) begin
    while (snap_q.size() > 0) begin
      snap_t s;
      int    got;
      s = snap_q.pop_front();
      got = get_f(s.unit, s.field);
      checks = checks + 1;
      if (got != s.exp) begin
        failures = failures + 1;
        $display("FAIL %s: got %0d expected %0d", s.name, got, s.exp);
      end
    end
    if (req[0] && !req_prev) begin
      checks = checks + 1;
      if (mv_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL unexpected_move_req: got 1 expected 0");
      end else begin
        int e, got;
        e = mv_q.pop_front();
        got = pack_mv(int'(sx[0]), int'(sy[0]), int'(dx[0]), int'(dy[0]));
        if (got != e) begin
          failures = failures + 1;
          $display("FAIL move_cmd: got %03h expected %03h", got, e);
        end
      end
    end
    if (go[1] && !go_prev) begin
      checks = checks + 1;
      if (win_q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL unexpected_game_over: got 1 expected 0");
      end else begin
        int e;
        e = win_q.pop_front();
        if (int'(win[1]) != e) begin
          failures = failures + 1;
          $display("FAIL winner_at_flag: got %0d expected %0d", win[1], e);
        end
      end
    end
    req_prev <= req[0];
    go_prev  <= go[1];
    if (done) begin
      checks = checks + 1;
      if (mv_q.size() != 0) begin
        failures = failures + 1;
        $display("FAIL moves_pending: got %0d expected 0", mv_q.size());
      end
      checks = checks + 1;
      if (win_q.size() != 0) begin
        failures = failures + 1;
        $display("FAIL flag_pending: got %0d expected 0", win_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      btn[u] = '0; team[u] = NA; ack[u] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int u = 0; u < 2; u++) begin
      expect_f(u, FCX, 0, "rst_cx");
      expect_f(u, FCY, 0, "rst_cy");
      expect_f(u, FTURN, 0, "rst_turn");
      expect_f(u, FREQ, 0, "rst_req");
      expect_f(u, FGO, 0, "rst_game_over");
      expect_f(u, FPICK, 0, "rst_picked");
      expect_f(u, FCNT, 0, "rst_count");
    end
    expect_f(0, FWS, int'(A_START), "rst_white_secs");
    expect_f(0, FBS, int'(A_START), "rst_black_secs");
    expect_f(1, FBS, 2, "rst_b_black_secs");

    // Cursor wrap in both axes, and right beating sel.
    press(0, B_LEFT, NA);
    repeat (3) press(0, B_DOWN, NA);
    expect_f(0, FCX, 7, "left_wrap_x");
    expect_f(0, FCY, 3, "down_y");
    press(0, B_RIGHT, NA);
    expect_f(0, FCX, 0, "right_wrap_x");
    expect_f(0, FCY, 3, "right_wrap_y");
    repeat (2) press(0, B_RIGHT, NA);
    repeat (3) press(0, B_UP, NA);
    expect_f(0, FCY, 0, "up_to_0");
    press(0, B_UP, NA);
    expect_f(0, FCY, 7, "up_wrap_y");
    expect_f(0, FCX, 2, "up_wrap_x");
    press(0, B_RIGHT | B_SEL, WH);
    expect_f(0, FCX, 3, "right_sel_cx");
    expect_f(0, FPICK, 0, "right_sel_no_pick");

    // White picks: opponent piece refused, own piece accepted, empty square targeted.
    press(0, B_SEL, BL);
    expect_f(0, FPICK, 0, "pick_opponent");
    press(0, B_RIGHT, NA);
    press(0, B_UP, NA);
    press(0, B_SEL, WH);
    expect_f(0, FPICK, 1, "pick_own");
    expect_f(0, FSX, 4, "pick_src_x");
    expect_f(0, FSY, 6, "pick_src_y");
    repeat (2) press(0, B_UP, NA);
    mv_q.push_back(pack_mv(4, 6, 4, 4));
    press(0, B_SEL, NA);
    expect_f(0, FREQ, 1, "issue_req");
    expect_f(0, FDX, 4, "issue_dst_x");
    expect_f(0, FDY, 4, "issue_dst_y");

    // Hold without ack; cursor press during ISSUE is ignored.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      btn[0] = (i == 0) ? B_RIGHT : 5'b0;
      expect_f(0, FREQ, 1, "hold_req");
      expect_f(0, FMOVE, pack_mv(4, 6, 4, 4), "hold_src_dst");
    end
    expect_f(0, FCX, 4, "issue_cursor_frozen");
    ack_pulse(0);
    expect_f(0, FREQ, 0, "ack_req_drop");
    expect_f(0, FTURN, 1, "ack_turn");
    expect_f(0, FCNT, 1, "ack_count");
    expect_f(0, FPICK, 0, "ack_picked");
    expect_f(0, FWS, A_AFTER, "white_after_move");

    // Black: pick, cancel on source, re-pick, reselect, capture.
    press(0, B_SEL, BL);
    expect_f(0, FSY, 4, "black_src_y");
    press(0, B_SEL, BL);
    expect_f(0, FPICK, 0, "cancel_pick");
    press(0, B_SEL, BL);
    press(0, B_DOWN, NA);
    press(0, B_SEL, BL);
    expect_f(0, FPICK, 1, "reselect_picked");
    expect_f(0, FSY, 5, "reselect_src_y");
    press(0, B_DOWN, NA);
    mv_q.push_back(pack_mv(4, 5, 4, 6));
    press(0, B_SEL, WH);
    expect_f(0, FREQ, 1, "capture_req");
    ack_pulse(0);
    expect_f(0, FTURN, 0, "black_ack_turn");
    expect_f(0, FCNT, 2, "black_ack_count");
    expect_f(0, FBS, A_AFTER, "black_after_move");
    ack_pulse(0);
    expect_f(0, FCNT, 2, "stray_ack_count");
    expect_f(0, FTURN, 0, "stray_ack_turn");

    // Unit 1: first white move untimed, then black flags in 2 x 4 cycles.
    win_q.push_back(0);
    press(1, B_SEL, WH);
    press(1, B_DOWN, NA);
    press(1, B_SEL, NA);
    repeat (6) @(posedge clk);
    #1;
    expect_f(1, FWS, 2, "untimed_first_move");
    expect_f(1, FREQ, 1, "b_req");
    ack_pulse(1);
    expect_f(1, FBS, 2, "b_secs_start");
    expect_f(1, FTURN, 1, "b_turn");
    repeat (3) @(posedge clk);
    #1 expect_f(1, FBS, 2, "b_secs_before_tick");
    @(posedge clk);
    #1 expect_f(1, FBS, 1, "b_secs_tick1");
    expect_f(1, FGO, 0, "b_not_over");
    repeat (3) @(posedge clk);
    #1 expect_f(1, FBS, 1, "b_secs_hold1");
    @(posedge clk);
    #1 expect_f(1, FBS, 0, "b_secs_tick2");
    expect_f(1, FGO, 1, "b_game_over");
    expect_f(1, FWIN, 0, "b_winner");
    expect_f(1, FWS, 2, "b_white_untouched");
    press(1, B_SEL, BL);
    expect_f(1, FPICK, 0, "over_sel_ignored");
    press(1, B_RIGHT, NA);
    expect_f(1, FCX, 0, "over_cursor_ignored");
    repeat (10) @(posedge clk);
    #1 expect_f(1, FBS, 0, "secs_floor");
    expect_f(1, FGO, 1, "over_sticky");

    @(posedge clk);
    #1 done = 1'b1;
  end

endmodule
